// File: rtl/sym_lut_pkg.sv
// Shared constants for the ping-pong IB node-update LUT bank: FSM encodings,
// page count and the per-port slicing helper for packed read buses.
package sym_lut_pkg;

  localparam int PAGE_NUM = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_FULL = 2'd2;

  // LSB position of port 'port' within a packed bus of 'width'-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/sym_lut_page.sv
// One LUT page: DEPTH x DATA_W storage, a single synchronous write port and
// RD_PORTS independent asynchronous read ports.
module sym_lut_page
  import sym_lut_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 7,
  parameter int RD_PORTS = 4
) (
  input  logic                         write_clk,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage arrays are deliberately left out of reset so they map onto
  // distributed RAM; contents are only meaningful once a load has written them.
  always_ff @(posedge write_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    assign rd_data[port_lsb(p, DATA_W) +: DATA_W] = mem[rd_addr[port_lsb(p, ADDR_W) +: ADDR_W]];
  end

endmodule

// File: rtl/sym_lut_pingpong_bank.sv
// Active/shadow LUT bank: a streaming loader fills the shadow page while
// readers see the active page; swap_req promotes it. SYM_LUT_RD_REG_EN registers read_data.
module sym_lut_pingpong_bank
  import sym_lut_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 7,
  parameter int RD_PORTS = 4
) (
  input  logic                         write_clk,
  input  logic                         rst,
  input  logic                         load_start,
  input  logic                         load_valid,
  input  logic [DATA_W-1:0]            load_data,
  output logic                         load_ready,
  output logic                         load_done,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         load_err,
  output logic                         active_page,
  input  logic [RD_PORTS*ADDR_W-1:0]   read_addr,
  output logic [RD_PORTS*DATA_W-1:0]   read_data
);

  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                     state;
  logic [ADDR_W-1:0]          waddr;
  logic                       wr_en;
  logic [PAGE_NUM-1:0]        page_we;
  logic [RD_PORTS*DATA_W-1:0] page_rdata [PAGE_NUM];
  logic [RD_PORTS*DATA_W-1:0] read_mux;

  assign load_ready = (state == ST_LOAD);
  // A beat that coincides with a restart is dropped.
  assign wr_en      = load_ready & load_valid & ~load_start;

  for (genvar pg = 0; pg < PAGE_NUM; pg++) begin : g_page
    assign page_we[pg] = wr_en && (active_page != 1'(pg));

    sym_lut_page #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .RD_PORTS (RD_PORTS)
    ) u_page (
      .write_clk (write_clk),
      .wr_en     (page_we[pg]),
      .wr_addr   (waddr),
      .wr_data   (load_data),
      .rd_addr   (read_addr),
      .rd_data   (page_rdata[pg])
    );
  end

  assign read_mux = page_rdata[active_page];

  // NOTE: all state here is sequential, so every assignment uses <= to keep
  // the edge-to-edge ordering independent of statement order.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      waddr       <= '0;
      active_page <= 1'b0;
      load_done   <= 1'b0;
      swap_ack    <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      swap_ack  <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          load_err <= swap_req;
          if (load_start) begin
            state <= ST_LOAD;
            waddr <= '0;
          end
        end
        ST_LOAD: begin
          load_err <= swap_req | load_start;
          if (load_start) begin
            waddr <= '0;
          end else if (load_valid) begin
            waddr <= waddr + 1'b1;
            if (waddr == LAST_ADDR) begin
              state     <= ST_FULL;
              load_done <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (swap_req) begin
            active_page <= ~active_page;
            swap_ack    <= 1'b1;
            state       <= load_start ? ST_LOAD : ST_IDLE;
            waddr       <= '0;
          end else if (load_start) begin
            state <= ST_LOAD;
            waddr <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SYM_LUT_RD_REG_EN
  always_ff @(posedge write_clk) begin
    if (rst) read_data <= '0;
    else     read_data <= read_mux;
  end
`else
  assign read_data = read_mux;
`endif

endmodule
